// File: rtl/read_axi_buffer_if.sv
// AXI4 read-address and read-data channels between the refill engine (master)
// and the memory side (slave).
interface read_axi_buffer_if;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  modport master (
    output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/read_axi_buffer.sv
// Cache-line refill engine: one AXI4 INCR read burst per request, beats assembled
// into a line register. READ_AXI_BUFFER_FWD_EN adds an early-restart beat forward.

module read_axi_buffer_slot (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout
);
   always_ff @(posedge clk) begin
      if (rst)     dout <= '0;
      else if (we) dout <= din;
   end
endmodule

module read_axi_buffer #(
   parameter int LINE_SIZE = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [31:0]            addr,
   output logic [LINE_SIZE*8-1:0] data,
   output logic                   done,
   output logic                   err,
   output logic                   empty,
   output logic                   fwd_valid,
   output logic [3:0]             fwd_idx,
   output logic [31:0]            fwd_data,
   read_axi_buffer_if.master      bus
);
   localparam int BEATS = LINE_SIZE / 4;
   localparam int OFS   = $clog2(LINE_SIZE);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       err_flag;
   logic       beat;
   logic       beat_err;
   logic       last_beat;

   assign empty     = (state == IDLE);
   // rready is only ever high in DATA, so the handshake alone marks a consumed beat
   assign beat      = bus.axi_rvalid & bus.axi_rready;
   assign last_beat = (cnt == 4'(BEATS - 1));
   assign beat_err  = (bus.axi_rresp != 2'b00) | (bus.axi_rlast != last_beat);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         err_flag        <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         bus.axi_araddr  <= '0;
         bus.axi_arlen   <= '0;
         bus.axi_arsize  <= '0;
         bus.axi_arburst <= '0;
         bus.axi_arvalid <= 1'b0;
         bus.axi_rready  <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: if (en) begin
               bus.axi_araddr  <= {addr[31:OFS], {OFS{1'b0}}};
               bus.axi_arlen   <= 8'(BEATS - 1);
               bus.axi_arsize  <= 3'b010;
               bus.axi_arburst <= 2'b01;
               bus.axi_arvalid <= 1'b1;
               cnt             <= '0;
               err_flag        <= 1'b0;
               state           <= ADDR;
            end
            ADDR: if (bus.axi_arready) begin
               bus.axi_arvalid <= 1'b0;
               bus.axi_rready  <= 1'b1;
               state           <= DATA;
            end
            DATA: if (beat) begin
               cnt      <= cnt + 4'd1;
               err_flag <= err_flag | beat_err;
               // burst length is fixed, so the counter rather than rlast ends it
               if (last_beat) begin
                  bus.axi_rready <= 1'b0;
                  done           <= 1'b1;
                  err            <= err_flag | beat_err;
                  state          <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < BEATS; g++) begin : g_slot
      read_axi_buffer_slot u_slot (
         .clk  (clk),
         .rst  (rst),
         .we   (beat && (cnt == 4'(g))),
         .din  (bus.axi_rdata),
         .dout (data[32*g +: 32])
      );
   end

`ifdef READ_AXI_BUFFER_FWD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_valid <= 1'b0;
         fwd_idx   <= '0;
         fwd_data  <= '0;
      end else begin
         fwd_valid <= beat;
         if (beat) begin
            fwd_idx  <= cnt;
            fwd_data <= bus.axi_rdata;
         end
      end
   end
`else
   assign fwd_valid = 1'b0;
   assign fwd_idx   = '0;
   assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_read_axi_buffer.sv
// Randomized bench for read_axi_buffer: bench acts as AXI slave, model is the
// expected line as an array of words plus an any-error flag.
module tb_read_axi_buffer;
  localparam int LINE_SIZE = 16;
  localparam int BEATS     = LINE_SIZE / 4;
  localparam int LW        = LINE_SIZE * 8;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [31:0]   addr;
  logic [LW-1:0] data;
  logic          done, err, empty, fwd_valid;
  logic [3:0]    fwd_idx;
  logic [31:0]   fwd_data;

  read_axi_buffer_if bus();

  read_axi_buffer #(.LINE_SIZE(LINE_SIZE)) dut (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .data(data), .done(done),
    .err(err), .empty(empty), .fwd_valid(fwd_valid), .fwd_idx(fwd_idx),
    .fwd_data(fwd_data), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] line_words [BEATS];

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[32*i +: 32] = line_words[i];
    return l;
  endfunction

  // One request; bad_resp / bad_last select a beat to corrupt (-1 = none).
  task automatic run_req(input logic [31:0] a, input int ar_dly, input int max_gap,
                         input int bad_resp, input int bad_last, input bit fixed);
    logic [31:0] exp_addr;
    logic [31:0] w;
    bit          e;
    int          gap;
    exp_addr = a & ~32'(LINE_SIZE - 1);
    e = 1'b0;
    chk("idle_empty", empty, 1);
    chk("idle_arvalid", bus.axi_arvalid, 0);
    en = 1'b1; addr = a;
    @(negedge clk);
    en = 1'b0; addr = $urandom;
    for (int c = 0; ; c++) begin
      chk("arvalid", bus.axi_arvalid, 1);
      chk("araddr", bus.axi_araddr, exp_addr);
      chk("arlen", bus.axi_arlen, BEATS - 1);
      chk("arsize", bus.axi_arsize, 2);
      chk("arburst", bus.axi_arburst, 1);
      chk("rready_addr", bus.axi_rready, 0);
      chk("empty_addr", empty, 0);
      if (c == ar_dly) break;
      en = (c == 0);
      @(negedge clk);
      en = 1'b0;
    end
    bus.axi_arready = 1'b1;
    @(negedge clk);
    bus.axi_arready = 1'b0;
    chk("arvalid_clr", bus.axi_arvalid, 0);
    chk("rready_data", bus.axi_rready, 1);
    for (int i = 0; i < BEATS; i++) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        chk("rready_gap", bus.axi_rready, 1);
        chk("done_gap", done, 0);
        en = 1'($urandom_range(0, 1));
        @(negedge clk);
        en = 1'b0;
      end
      w = fixed ? 32'(i + 1) * 32'h11 : $urandom;
      bus.axi_rvalid = 1'b1;
      bus.axi_rdata  = w;
      bus.axi_rresp  = (i == bad_resp) ? 2'b10 : 2'b00;
      bus.axi_rlast  = (bad_last >= 0) ? (i == bad_last) : (i == BEATS - 1);
      line_words[i] = w;
      if (bus.axi_rresp != 2'b00 || bus.axi_rlast != (i == BEATS - 1)) e = 1'b1;
      @(negedge clk);
      bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0; bus.axi_rresp = 2'b00;
`ifdef READ_AXI_BUFFER_FWD_EN
      chk("fwd_valid", fwd_valid, 1);
      chk("fwd_idx", fwd_idx, i);
      chk("fwd_data", fwd_data, w);
`else
      chk("fwd_valid_off", fwd_valid, 0);
      chk("fwd_idx_off", fwd_idx, 0);
      chk("fwd_data_off", fwd_data, 0);
`endif
      if (i < BEATS - 1) chk("done_early", done, 0);
    end
    chk("done", done, 1);
    chk("err", err, e);
    chk("data", data, model_line());
    chk("empty_done", empty, 0);
    chk("rready_done", bus.axi_rready, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("empty_after", empty, 1);
`ifdef READ_AXI_BUFFER_FWD_EN
    chk("fwd_valid_drop", fwd_valid, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; addr = '0;
    bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0;
    bus.axi_rresp = 2'b00; bus.axi_rlast = 1'b0;
    for (int i = 0; i < BEATS; i++) line_words[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_arvalid", bus.axi_arvalid, 0);
    chk("rst_rready", bus.axi_rready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_araddr", bus.axi_araddr, 0);
    chk("rst_arlen", bus.axi_arlen, 0);
    chk("rst_data", data, 0);
    chk("rst_fwd", fwd_valid, 0);

    // stray beat while idle must not be consumed
    bus.axi_rvalid = 1'b1; bus.axi_rdata = 32'hDEAD_BEEF; bus.axi_rlast = 1'b1;
    @(negedge clk);
    chk("idle_rready", bus.axi_rready, 0);
    bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0;
    @(negedge clk);
    chk("idle_data", data, 0);

    run_req(32'h1000_003C, 0, 0, -1, -1, 1'b1);
    chk("dir_line", data, 128'h00000044_00000033_00000022_00000011);
    run_req(32'h2000_0104, 5, 3, -1, -1, 1'b0);
    run_req(32'h3000_0008, 1, 1, 2, -1, 1'b0);
    run_req(32'h4000_FFFF, 0, 2, -1, 1, 1'b0);
    for (int n = 0; n < 25; n++) begin
      run_req($urandom, $urandom_range(0, 4), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
              1'b0);
    end

    // reset in the middle of a burst
    en = 1'b1; addr = 32'h5000_0000;
    @(negedge clk);
    en = 1'b0; bus.axi_arready = 1'b1;
    @(negedge clk);
    bus.axi_arready = 1'b0;
    bus.axi_rvalid = 1'b1; bus.axi_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.axi_rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rready", bus.axi_rready, 0);
    chk("mid_rst_data", data, 0);
    for (int i = 0; i < BEATS; i++) line_words[i] = '0;
    @(negedge clk);
    run_req(32'h6000_0010, 2, 1, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
